// File: rtl/spi_nor_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the SPI NOR flash target.
package spi_nor_pkg;

   localparam logic [7:0]  OP_READ     = 8'h01;
   localparam logic [7:0]  OP_PROG     = 8'h02;
   localparam logic [7:0]  OP_RDSR     = 8'h05;
   localparam logic [31:0] ERASED_WORD = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_RDATA,
      ST_STAT,
      ST_SKIP
   } state_e;

   // Byte idx of a 32-bit word, MSB first (idx 0 = bits 31:24).
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/spi_nor_mem_array.sv
// DEPTH x 32 storage array: synchronous write, combinational read, erased on reset.
module spi_nor_mem_array
   import spi_nor_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= ERASED_WORD;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/spi_nor_flash_slave.sv
// Byte-lane SPI NOR flash target: decodes opcode/address/data frames, serves
// reads and status, and holds busy for PROG_CYCLES after a program commit.
module spi_nor_flash_slave
   import spi_nor_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int AW          = 4,
   parameter int PROG_CYCLES = 4
) (
   input  logic       p_clk,
   input  logic       p_reset_n,
   input  logic       s_css,
   input  logic       s_clk,
   input  logic [7:0] s_mosi,
   output logic [7:0] s_miso,
   output logic       busy
);

   localparam int CW = $clog2(PROG_CYCLES + 1);

   state_e         state_q, state_d;
   logic           s_clk_q;
   logic           sclk_rise;
   logic [1:0]     cnt_q, cnt_d;
   logic           is_prog_q, is_prog_d;
   logic [23:0]    addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [31:0]    rword_q, rword_d;
   logic [7:0]     miso_q, miso_d;
   logic           commit_q, commit_d;
   logic           busy_q, busy_d;
   logic [CW-1:0]  bcnt_q, bcnt_d;

   logic [23:0]    addr_full;
   logic           addr_oor;
   logic           waddr_oor;
   logic           last_byte;
   logic [31:0]    mem_rdata;
   logic [31:0]    fetch_word;

   assign sclk_rise  = s_clk & ~s_clk_q & ~s_css;
   // Address as it will look once the byte on s_mosi is shifted in.
   assign addr_full  = {addr_q[15:0], s_mosi};
   assign addr_oor   = (addr_full >= 24'(DEPTH));
   assign waddr_oor  = (addr_q >= 24'(DEPTH));
   assign last_byte  = (cnt_q == 2'd3);
   assign fetch_word = addr_oor ? ERASED_WORD : mem_rdata;

   spi_nor_mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (p_clk),
      .rst_n (p_reset_n),
      .we    (commit_q),
      .waddr (addr_q[AW-1:0]),
      .wdata (wdata_q),
      .raddr (addr_full[AW-1:0]),
      .rdata (mem_rdata)
   );

   always_ff @(posedge p_clk or negedge p_reset_n) begin
      if (!p_reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (s_css) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_CMD;
            ST_CMD: begin
               if (sclk_rise) begin
                  // Registered busy gates READ/PROG; status is always served.
                  if ((s_mosi == OP_READ || s_mosi == OP_PROG) && !busy_q) begin
                     state_d = ST_ADDR;
                  end else if (s_mosi == OP_RDSR) begin
                     state_d = ST_STAT;
                  end else begin
                     state_d = ST_SKIP;
                  end
               end
            end
            ST_ADDR: begin
               if (sclk_rise && cnt_q == 2'd2) begin
                  state_d = is_prog_q ? ST_WDATA : ST_RDATA;
               end
            end
            ST_WDATA, ST_RDATA: begin
               if (sclk_rise && last_byte) begin
                  state_d = ST_SKIP;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      is_prog_d = is_prog_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rword_d   = rword_q;
      miso_d    = 8'h00;
      commit_d  = 1'b0;
      if (s_css) begin
         cnt_d     = '0;
         is_prog_d = 1'b0;
         addr_d    = '0;
         wdata_d   = '0;
         rword_d   = '0;
      end else begin
         case (state_q)
            ST_CMD: begin
               if (sclk_rise) begin
                  is_prog_d = (s_mosi == OP_PROG);
                  cnt_d     = '0;
               end
            end
            ST_ADDR: begin
               if (sclk_rise) begin
                  addr_d = addr_full;
                  cnt_d  = (cnt_q == 2'd2) ? 2'd0 : cnt_q + 2'd1;
                  if (cnt_q == 2'd2 && !is_prog_q) begin
                     rword_d = fetch_word;
                     miso_d  = word_byte(fetch_word, 2'd0);
                  end
               end
            end
            ST_WDATA: begin
               if (sclk_rise) begin
                  wdata_d  = {wdata_q[23:0], s_mosi};
                  cnt_d    = cnt_q + 2'd1;
                  commit_d = last_byte && !waddr_oor;
               end
            end
            ST_RDATA: begin
               // The final byte stays on the lane until the FSM leaves RDATA.
               miso_d = miso_q;
               if (sclk_rise) begin
                  cnt_d = cnt_q + 2'd1;
                  if (!last_byte) begin
                     miso_d = word_byte(rword_q, cnt_q + 2'd1);
                  end
               end
            end
            ST_STAT: miso_d = {7'b0, busy_q};
            default: ;
         endcase
      end
   end

   always_comb begin
      bcnt_d = bcnt_q;
      if (commit_q) begin
         bcnt_d = CW'(PROG_CYCLES);
      end else if (bcnt_q != '0) begin
         bcnt_d = bcnt_q - CW'(1);
      end
      busy_d = (bcnt_d != '0);
   end

   always_ff @(posedge p_clk or negedge p_reset_n) begin
      if (!p_reset_n) begin
         s_clk_q   <= 1'b0;
         cnt_q     <= '0;
         is_prog_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rword_q   <= '0;
         miso_q    <= '0;
         commit_q  <= 1'b0;
         busy_q    <= 1'b0;
         bcnt_q    <= '0;
      end else begin
         s_clk_q   <= s_clk;
         cnt_q     <= cnt_d;
         is_prog_q <= is_prog_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rword_q   <= rword_d;
         miso_q    <= miso_d;
         commit_q  <= commit_d;
         busy_q    <= busy_d;
         bcnt_q    <= bcnt_d;
      end
   end

   assign s_miso = miso_q;
   assign busy   = busy_q;

endmodule

// File: doc/spi_nor_flash_slave.md
# spi_nor_flash_slave

Synthesizable byte-lane SPI NOR flash target sitting directly downstream of the APB-to-SPI NOR flash controller. It consumes the controller's `s_css`/`s_clk`/`s_mosi` frames, decodes opcode, 24-bit address and 32-bit data, and returns read data or status on `s_miso`. It also serves as the bench-side flash model for controller regressions. Program operations hold the device busy for a fixed time.

## Interface
- `DEPTH`, 16: number of 32-bit words in the array.
- `AW`, 4: word-index width, $clog2(DEPTH).
- `PROG_CYCLES`, 4: p_clk cycles the device stays busy after a program commit; must be ≥1.
- `p_clk` in 1: single clock. `s_clk` is generated synchronously to it.
- `p_reset_n` in 1: asynchronous, active-low reset.
- `s_css` in 1: chip select, active low, frames a transaction.
- `s_clk` in 1: SPI byte clock; one byte transfers per rising edge.
- `s_mosi` in 8: command, address and write-data byte lane.
- `s_miso` out 8: read-data and status byte lane.
- `busy` out 1: program in progress; mirrors status bit 0.

## Operation
- Edge detect: `s_clk_q` is a registered copy of `s_clk`. `sclk_rise = s_clk & ~s_clk_q & ~s_css`. All byte captures occur on p_clk edges where `sclk_rise` = 1.
- Opcodes: 0x01 READ, 0x02 PROGRAM, 0x05 READ_STATUS. Any other opcode moves the FSM to SKIP.
- Frame layout: byte0 opcode; bytes1–3 address A[23:16], A[15:8], A[7:0]; bytes4–7 data D[31:24]..D[7:0]. All fields are MSB first.
- Word index = A[AW-1:0]. The address is out of range when A ≥ DEPTH.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, STAT, SKIP.
  - IDLE→CMD when `s_css` falls.
  - CMD→ADDR on an opcode byte of 0x01 or 0x02.
  - CMD→STAT on 0x05.
  - ADDR (3 bytes)→WDATA or RDATA.
  - WDATA and RDATA run 4 bytes, then go to SKIP.
  - `s_css` high returns the FSM to IDLE from any state in the same cycle. The byte counter and shift registers clear.
- Busy gating: an opcode of 0x01 or 0x02 received while `busy`=1 goes to SKIP. 0x05 is always accepted.
- PROGRAM: after the 4th data byte, the word is written to the array on the next p_clk. `busy` asserts in that same cycle.
  - No write occurs if the address is out of range.
  - No write occurs if `s_css` rises before the 4th data byte; a partial word is discarded.
- READ: on the edge capturing A[7:0], the word is fetched. An out-of-range address returns 0xFFFFFFFF.
- STAT: `s_miso` = {7'b0, busy}, refreshed every p_clk while in STAT.
- Extra bytes beyond byte 7 are ignored in SKIP.
- Reset values: every array word = 0xFFFFFFFF (erased); FSM = IDLE; `s_miso` = 0x00; `busy` = 0; busy counter = 0.

## Timing
- `s_mosi` is sampled in the p_clk cycle where `sclk_rise`=1. The controller must hold the byte stable across that edge.
- READ output sequence:
  - D[31:24] appears on `s_miso` one p_clk after the A[7:0] capture cycle.
  - Each later `sclk_rise` in RDATA advances `s_miso` to the next byte one p_clk later: D[23:16], D[15:8], D[7:0].
  - `s_miso` returns to 0x00 one p_clk after `s_css` rises or after leaving RDATA/STAT.
- PROGRAM timing:
  - Array write and `busy`↑ happen one p_clk after the D[7:0] capture.
  - `busy` stays high exactly PROG_CYCLES p_clk cycles, then ↓.
  - A READ opcode captured in the cycle `busy` falls is still skipped, because the registered busy value is compared.
- Simultaneous `s_css`↑ and `sclk_rise` is impossible, since `sclk_rise` is gated by `~s_css`. The frame aborts.
- Reset mid-frame or mid-program: immediate return to the reset state. The array is reinitialised to erased.

## Structure
- Package `spi_nor_pkg` holds:
  - opcode constants OP_READ=8'h01, OP_PROG=8'h02, OP_RDSR=8'h05;
  - the state enum;
  - ERASED_WORD=32'hFFFF_FFFF.
- One sub-module is natural: `spi_nor_mem_array`, a DEPTH×32 register array.
  - It has a synchronous write port and a combinational read port.
  - It initialises to erased on async reset.
- The FSM, byte counter, shift registers and busy counter live in the top module.

## Test plan
- PROGRAM 0x02, addr 0x000000, data 0xFF00FF00 → word0 = 0xFF00FF00; `busy` high for 4 cycles, starting 1 cycle after the last data byte.
- After busy clears, READ 0x01 addr 0x000000 → `s_miso` sequence 0xFF, 0x00, 0xFF, 0x00, each 1 p_clk after its `s_clk` rise.
- READ_STATUS during a program → `s_miso`=0x01; repeat after busy clears → 0x00. READ issued while busy → `s_miso` stays 0x00 and the array is unchanged.
- PROGRAM to addr 0x000005 with data 0x12345678, `s_css` raised after 2 data bytes → word5 remains 0xFFFFFFFF; `busy` never asserts.
- PROGRAM to addr 0x000020 (out of range) → no array change; READ of addr 0x000020 → 0xFF ×4.
- Opcode 0x9F → all bytes ignored and `s_miso`=0x00. Assert `p_reset_n` mid-READ → `s_miso`=0x00, FSM IDLE, word0 erased.
